// File: rtl/mult8_pkg.sv
// Shared widths and types for the mult_8 tile driver and its result buffer.
package mult8_pkg;
  localparam int OPW         = 8;
  localparam int PRODW       = 16;
  localparam int LATENCY_MAX = 4;

  typedef logic [OPW-1:0]   operand_t;
  typedef logic [PRODW-1:0] product_t;
endpackage

// File: rtl/mult8_res_fifo.sv
// Synchronous result FIFO, valid/ready read side; write lands the next edge.
// A write while full is accepted only when a pop happens on the same edge.
module mult8_res_fifo
  import mult8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [PRODW-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [PRODW-1:0] rd_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  product_t       mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;

  // The extra top bit distinguishes full from empty when the addresses match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign push     = wr_en && (!full || pop);
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/mult8_tile_driver.sv
// Drives a mult_8 tile: registers operands onto its pins, tags each accept through
// the tile latency, buffers products; credits stop accepts once DEPTH are owed.
// Optional MULT8_TILE_DRIVER_CHECK_EN adds a sticky chk_err product self-check.
module mult8_tile_driver
  import mult8_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OPW-1:0]   op_a,
  input  logic [OPW-1:0]   op_b,
  output logic [OPW-1:0]   tile_a,
  output logic [OPW-1:0]   tile_b,
  input  logic [PRODW-1:0] tile_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PRODW-1:0] res_data,
`ifdef MULT8_TILE_DRIVER_CHECK_EN
  output logic             chk_err,
`endif
  output logic             busy
);
  localparam int LAT = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam int CW  = $clog2(DEPTH) + 1;

  logic          accept;
  logic          pop;
  logic          capture;
  logic [LAT:0]  tag_sr;
  logic [CW-1:0] credit;

  assign op_ready = (credit < CW'(DEPTH));
  assign accept   = op_valid && op_ready;
  assign pop      = res_valid && res_ready;
  assign capture  = tag_sr[LAT];
  assign busy     = (credit != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_a <= '0;
      tile_b <= '0;
      tag_sr <= '0;
      credit <= '0;
    end else begin
      if (accept) begin
        tile_a <= op_a;
        tile_b <= op_b;
      end
      tag_sr[0] <= accept;
      for (int i = 1; i <= LAT; i++) tag_sr[i] <= tag_sr[i-1];
      case ({accept, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  mult8_res_fifo #(.DEPTH(DEPTH)) u_res_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (capture),
    .wr_data  (tile_out),
    .rd_valid (res_valid),
    .rd_ready (res_ready),
    .rd_data  (res_data)
  );

`ifdef MULT8_TILE_DRIVER_CHECK_EN
  // Operands ride alongside their tag so the exiting product can be checked.
  operand_t chk_a [LAT+1];
  operand_t chk_b [LAT+1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_err <= 1'b0;
      for (int i = 0; i <= LAT; i++) begin
        chk_a[i] <= '0;
        chk_b[i] <= '0;
      end
    end else begin
      chk_a[0] <= op_a;
      chk_b[0] <= op_b;
      for (int i = 1; i <= LAT; i++) begin
        chk_a[i] <= chk_a[i-1];
        chk_b[i] <= chk_b[i-1];
      end
      if (capture && (tile_out != (product_t'(chk_a[LAT]) * product_t'(chk_b[LAT]))))
        chk_err <= 1'b1;
    end
  end
`endif
endmodule
